// File: rtl/up_initiator.sv
// up_initiator: turns a valid/ready command stream into single up-bus read or
// write requests. It waits for the matching ack or a timeout, then returns one
// response. Only one transaction is in flight at a time.
//
// Handshakes: cmd and rsp follow strict valid/ready semantics. A beat transfers
// on a rising edge where valid and ready are both high. valid never depends on
// ready. rsp_rdata/rsp_error hold steady while rsp_valid is high and unaccepted.
module up_initiator #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int BUS_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [BUS_WIDTH*8-1:0]   cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BUS_WIDTH*8-1:0]   rsp_rdata,
  output logic                     rsp_error,
  output logic                     up_rreq,
  input  logic                     up_rack,
  output logic [ADDRESS_WIDTH-1:0] up_raddr,
  input  logic [BUS_WIDTH*8-1:0]   up_rdata,
  output logic                     up_wreq,
  input  logic                     up_wack,
  output logic [ADDRESS_WIDTH-1:0] up_waddr,
  output logic [BUS_WIDTH*8-1:0]   up_wdata,
  output logic                     busy,
  output logic [1:0]               fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // A zero-width counter is not legal, so the disabled case keeps one bit.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  // The request has been high TIMEOUT_CYCLES cycles when this value is seen
  // with the ack still low on the current edge.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          accept;
  logic          in_req;
  logic          ack_now;
  logic          timeout;

  assign accept  = cmd_valid & cmd_ready;
  assign in_req  = (state_q == READ) || (state_q == WRITE);
  assign ack_now = ((state_q == READ) & up_rack) | ((state_q == WRITE) & up_wack);
  assign timeout = TO_EN && in_req && !ack_now && (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; an ack on the timeout edge completes normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_write ? WRITE : READ;
      READ:    if (up_rack || timeout) state_d = RESP;
      WRITE:   if (up_wack || timeout) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    cmd_ready = (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    busy      = (state_q != IDLE);
    fsm_state = state_q;
  end

  // Registered request strobes, derived from the upcoming state so they rise
  // the cycle after accept and fall the cycle after completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_rreq <= 1'b0;
      up_wreq <= 1'b0;
    end else begin
      up_rreq <= (state_d == READ);
      up_wreq <= (state_d == WRITE);
    end
  end

  // Command latches; they keep their last value while idle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      up_raddr <= '0;
      up_waddr <= '0;
      up_wdata <= '0;
    end else if (accept) begin
      if (cmd_write) begin
        up_waddr <= cmd_addr;
        up_wdata <= cmd_wdata;
      end else begin
        up_raddr <= cmd_addr;
      end
    end
  end

  // Timeout counter: cleared on accept, saturating count of ack-less cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (in_req && !ack_now && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Response payload, captured once when the transaction finishes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if ((state_q == READ) && up_rack) begin
      rsp_rdata <= up_rdata;
      rsp_error <= 1'b0;
    end else if ((state_q == WRITE) && up_wack) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
    end else if (timeout) begin
      rsp_rdata <= '0;
      rsp_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_up_initiator.sv
// Directed bench for up_initiator with a short timeout (4 cycles).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_up_initiator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        up_rreq;
  logic        up_rack;
  logic [31:0] up_raddr;
  logic [31:0] up_rdata;
  logic        up_wreq;
  logic        up_wack;
  logic [31:0] up_waddr;
  logic [31:0] up_wdata;
  logic        busy;
  logic [1:0]  fsm_state;

  int checks   = 0;
  int failures = 0;

  up_initiator #(
    .ADDRESS_WIDTH (32),
    .BUS_WIDTH     (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .up_rreq  (up_rreq),
    .up_rack  (up_rack),
    .up_raddr (up_raddr),
    .up_rdata (up_rdata),
    .up_wreq  (up_wreq),
    .up_wack  (up_wack),
    .up_waddr (up_waddr),
    .up_wdata (up_wdata),
    .busy     (busy),
    .fsm_state(fsm_state)
  );

  // clock
  always #5 clk = ~clk;

  // Present one command in IDLE and return in the first request cycle.
  task automatic accept_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL accept_cmd_ready actual=%0h expected=1", cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; up_rack = 1'b1; up_wack = 1'b1; up_rdata = 32'hFFFF_FFFF;
    #3;
    checks++; if (up_rreq !== 1'b0)   begin failures++; $display("FAIL reset_rreq actual=%0h expected=0", up_rreq); end
    checks++; if (up_wreq !== 1'b0)   begin failures++; $display("FAIL reset_wreq actual=%0h expected=0", up_wreq); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid actual=%0h expected=0", rsp_valid); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL reset_rsp_error actual=%0h expected=0", rsp_error); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy actual=%0h expected=0", busy); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp_rdata actual=%0h expected=0", rsp_rdata); end
    checks++; if (up_raddr !== 32'h0) begin failures++; $display("FAIL reset_raddr actual=%0h expected=0", up_raddr); end
    checks++; if (up_waddr !== 32'h0) begin failures++; $display("FAIL reset_waddr actual=%0h expected=0", up_waddr); end
    checks++; if (up_wdata !== 32'h0) begin failures++; $display("FAIL reset_wdata actual=%0h expected=0", up_wdata); end
    checks++; if (fsm_state !== 2'd0) begin failures++; $display("FAIL reset_state actual=%0h expected=0", fsm_state); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    // Acks held high while idle must not start anything.
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL idle_ack_busy actual=%0h expected=0", busy); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL idle_cmd_ready actual=%0h expected=1", cmd_ready); end
    up_rack = 1'b0; up_wack = 1'b0; up_rdata = '0;
  endtask

  task automatic test_read();
    accept_cmd(1'b0, 32'h004, 32'h0);
    checks++; if (up_rreq !== 1'b1)     begin failures++; $display("FAIL read_rreq_c1 actual=%0h expected=1", up_rreq); end
    checks++; if (up_raddr !== 32'h004) begin failures++; $display("FAIL read_raddr_c1 actual=%0h expected=4", up_raddr); end
    checks++; if (cmd_ready !== 1'b0)   begin failures++; $display("FAIL read_cmd_ready actual=%0h expected=0", cmd_ready); end
    checks++; if (busy !== 1'b1)        begin failures++; $display("FAIL read_busy actual=%0h expected=1", busy); end
    @(negedge clk);
    checks++; if (up_rreq !== 1'b1)     begin failures++; $display("FAIL read_rreq_c2 actual=%0h expected=1", up_rreq); end
    checks++; if (up_raddr !== 32'h004) begin failures++; $display("FAIL read_raddr_c2 actual=%0h expected=4", up_raddr); end
    up_rack = 1'b1; up_rdata = 32'h0000_00A5;
    @(negedge clk);
    up_rack = 1'b0; up_rdata = '0;
    checks++; if (up_rreq !== 1'b0)          begin failures++; $display("FAIL read_rreq_drop actual=%0h expected=0", up_rreq); end
    checks++; if (rsp_valid !== 1'b1)        begin failures++; $display("FAIL read_rsp_valid actual=%0h expected=1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0000_00A5) begin failures++; $display("FAIL read_rsp_rdata actual=%0h expected=a5", rsp_rdata); end
    checks++; if (rsp_error !== 1'b0)        begin failures++; $display("FAIL read_rsp_error actual=%0h expected=0", rsp_error); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0)   begin failures++; $display("FAIL read_rsp_done actual=%0h expected=0", rsp_valid); end
    checks++; if (cmd_ready !== 1'b1)   begin failures++; $display("FAIL read_back_idle actual=%0h expected=1", cmd_ready); end
    checks++; if (up_raddr !== 32'h004) begin failures++; $display("FAIL read_raddr_hold actual=%0h expected=4", up_raddr); end
  endtask

  task automatic test_write();
    int n;
    n = 0;
    accept_cmd(1'b1, 32'h000, 32'h0000_000F);
    if (up_wreq === 1'b1) n++;
    checks++; if (up_wdata !== 32'h0000_000F) begin failures++; $display("FAIL write_wdata_c1 actual=%0h expected=f", up_wdata); end
    checks++; if (up_waddr !== 32'h0)         begin failures++; $display("FAIL write_waddr_c1 actual=%0h expected=0", up_waddr); end
    checks++; if (up_rreq !== 1'b0)           begin failures++; $display("FAIL write_no_rreq actual=%0h expected=0", up_rreq); end
    @(negedge clk);
    if (up_wreq === 1'b1) n++;
    checks++; if (up_wdata !== 32'h0000_000F) begin failures++; $display("FAIL write_wdata_c2 actual=%0h expected=f", up_wdata); end
    up_wack = 1'b1;
    @(negedge clk);
    up_wack = 1'b0;
    if (up_wreq === 1'b1) n++;
    checks++; if (n != 2)             begin failures++; $display("FAIL write_wreq_cycles actual=%0d expected=2", n); end
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL write_rsp_valid actual=%0h expected=1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL write_rsp_rdata actual=%0h expected=0", rsp_rdata); end
    checks++; if (rsp_error !== 1'b0) begin failures++; $display("FAIL write_rsp_error actual=%0h expected=0", rsp_error); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_idle actual=%0h expected=0", busy); end
  endtask

  // Ack arrives on the 4th request cycle, the same edge the timeout would fire.
  task automatic test_timeout_ack();
    accept_cmd(1'b0, 32'h020, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      checks++; if (up_rreq !== 1'b1) begin failures++; $display("FAIL to_ack_rreq_c%0d actual=%0h expected=1", i, up_rreq); end
      @(negedge clk);
    end
    up_rack = 1'b1; up_rdata = 32'h0000_005A;
    @(negedge clk);
    up_rack = 1'b0; up_rdata = '0;
    checks++; if (rsp_valid !== 1'b1)        begin failures++; $display("FAIL to_ack_rsp_valid actual=%0h expected=1", rsp_valid); end
    checks++; if (rsp_error !== 1'b0)        begin failures++; $display("FAIL to_ack_rsp_error actual=%0h expected=0", rsp_error); end
    checks++; if (rsp_rdata !== 32'h0000_005A) begin failures++; $display("FAIL to_ack_rsp_rdata actual=%0h expected=5a", rsp_rdata); end
    @(negedge clk);
  endtask

  // No read ack; a stray write ack during READ must be ignored.
  task automatic test_timeout_noack();
    int n;
    int waited;
    n = 0;
    waited = 0;
    accept_cmd(1'b0, 32'h010, 32'h0);
    up_wack = 1'b1;
    while (rsp_valid !== 1'b1 && waited < 20) begin
      if (up_rreq === 1'b1) n++;
      @(negedge clk);
      waited++;
    end
    up_wack = 1'b0;
    checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL to_rsp_valid actual=%0h expected=1 waited=%0d", rsp_valid, waited); end
    checks++; if (n != 4)             begin failures++; $display("FAIL to_rreq_cycles actual=%0d expected=4", n); end
    checks++; if (rsp_error !== 1'b1) begin failures++; $display("FAIL to_rsp_error actual=%0h expected=1", rsp_error); end
    checks++; if (rsp_rdata !== 32'h0) begin failures++; $display("FAIL to_rsp_rdata actual=%0h expected=0", rsp_rdata); end
    checks++; if (up_rreq !== 1'b0)   begin failures++; $display("FAIL to_rreq_drop actual=%0h expected=0", up_rreq); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL to_rsp_done actual=%0h expected=0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    accept_cmd(1'b0, 32'h030, 32'h0);
    up_rack = 1'b1; up_rdata = 32'h0000_1234;
    @(negedge clk);
    up_rack = 1'b0; up_rdata = '0;
    // A competing write command is offered while the response is stalled.
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h040; cmd_wdata = 32'h0000_DEAD;
    for (int i = 0; i < 5; i++) begin
      checks++; if (rsp_valid !== 1'b1)          begin failures++; $display("FAIL bp_rsp_valid_%0d actual=%0h expected=1", i, rsp_valid); end
      checks++; if (rsp_rdata !== 32'h0000_1234) begin failures++; $display("FAIL bp_rsp_rdata_%0d actual=%0h expected=1234", i, rsp_rdata); end
      checks++; if (cmd_ready !== 1'b0)          begin failures++; $display("FAIL bp_cmd_ready_%0d actual=%0h expected=0", i, cmd_ready); end
      checks++; if ((up_wreq | up_rreq) !== 1'b0) begin failures++; $display("FAIL bp_no_req_%0d actual=%0h expected=0", i, up_wreq | up_rreq); end
      @(negedge clk);
    end
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0)  begin failures++; $display("FAIL bp_rsp_done actual=%0h expected=0", rsp_valid); end
    checks++; if (up_wreq !== 1'b0)    begin failures++; $display("FAIL bp_wreq_after actual=%0h expected=0", up_wreq); end
    checks++; if (up_waddr !== 32'h0)  begin failures++; $display("FAIL bp_waddr_unlatched actual=%0h expected=0", up_waddr); end
  endtask

  task automatic test_reset_mid_write();
    accept_cmd(1'b1, 32'h050, 32'h0000_0077);
    checks++; if (up_wreq !== 1'b1)      begin failures++; $display("FAIL rmw_wreq_before actual=%0h expected=1", up_wreq); end
    checks++; if (up_waddr !== 32'h050)  begin failures++; $display("FAIL rmw_waddr_before actual=%0h expected=50", up_waddr); end
    #2;
    rstn = 1'b0;
    #1;
    checks++; if (up_wreq !== 1'b0)     begin failures++; $display("FAIL rmw_wreq_async actual=%0h expected=0", up_wreq); end
    checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL rmw_busy_async actual=%0h expected=0", busy); end
    checks++; if (up_waddr !== 32'h0)   begin failures++; $display("FAIL rmw_waddr_async actual=%0h expected=0", up_waddr); end
    checks++; if (up_wdata !== 32'h0)   begin failures++; $display("FAIL rmw_wdata_async actual=%0h expected=0", up_wdata); end
    checks++; if (rsp_rdata !== 32'h0)  begin failures++; $display("FAIL rmw_rsp_rdata_async actual=%0h expected=0", rsp_rdata); end
    @(negedge clk);
    rstn = 1'b1;
    up_wack = 1'b1;
    @(negedge clk);
    up_wack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ((rsp_valid | busy | up_wreq) !== 1'b0) begin failures++; $display("FAIL rmw_no_rsp_%0d actual=%0h expected=0", i, rsp_valid | busy | up_wreq); end
      @(negedge clk);
    end
    accept_cmd(1'b0, 32'h060, 32'h0);
    checks++; if (up_raddr !== 32'h060) begin failures++; $display("FAIL rmw_read_raddr actual=%0h expected=60", up_raddr); end
    up_rack = 1'b1; up_rdata = 32'h0000_CAFE;
    @(negedge clk);
    up_rack = 1'b0; up_rdata = '0;
    checks++; if (rsp_valid !== 1'b1)          begin failures++; $display("FAIL rmw_read_rsp_valid actual=%0h expected=1", rsp_valid); end
    checks++; if (rsp_rdata !== 32'h0000_CAFE) begin failures++; $display("FAIL rmw_read_rsp_rdata actual=%0h expected=cafe", rsp_rdata); end
    checks++; if (rsp_error !== 1'b0)          begin failures++; $display("FAIL rmw_read_rsp_error actual=%0h expected=0", rsp_error); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmw_read_idle actual=%0h expected=0", busy); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_timeout_ack();
    test_timeout_noack();
    test_backpressure();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit reached");
  end

endmodule

// File: doc/up_initiator.md
UP_INITIATOR -- requirements
Module: up_initiator

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 32, up address width.
REQ-002 SHALL have parameter BUS_WIDTH, default 4, data width in bytes (data = BUS_WIDTH*8 bits).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum request-high cycles without ack; 0 disables the timeout.
REQ-004 SHALL have ports:
- clk  in  1  sole clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when both high
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDRESS_WIDTH  target address
- cmd_wdata  in  BUS_WIDTH*8  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when both high
- rsp_rdata  out  BUS_WIDTH*8  read data (0 for writes and errors)
- rsp_error  out  1  1=timeout, no ack received
- up_rreq  out  1  read request
- up_rack  in  1  read acknowledge
- up_raddr  out  ADDRESS_WIDTH  read address
- up_rdata  in  BUS_WIDTH*8  read data, valid while up_rack high
- up_wreq  out  1  write request
- up_wack  in  1  write acknowledge
- up_waddr  out  ADDRESS_WIDTH  write address
- up_wdata  out  BUS_WIDTH*8  write data
- busy  out  1  high in any state other than IDLE

Function
REQ-005 SHALL implement FSM states IDLE, READ, WRITE, RESP; exactly one transaction outstanding.
REQ-006 cmd_ready SHALL be high only in IDLE (combinational from state); command accepted on an edge where cmd_valid & cmd_ready.
REQ-007 On accept, SHALL latch cmd_addr, cmd_wdata, cmd_write; enter READ (cmd_write=0) or WRITE (cmd_write=1).
REQ-008 up_rreq SHALL be high exactly in READ, up_wreq exactly in WRITE, both registered; request rises the cycle after accept.
REQ-009 up_raddr/up_waddr/up_wdata SHALL be driven from latched registers, stable for the whole request; they hold last value when idle.
REQ-010 In READ, on an edge with up_rack=1: capture up_rdata into rsp_rdata, rsp_error<=0, go RESP; up_rreq low next cycle.
REQ-011 In WRITE, on an edge with up_wack=1: rsp_rdata<=0, rsp_error<=0, go RESP; up_wreq low next cycle.
REQ-012 Ack inputs SHALL be ignored outside the matching state (up_wack in READ, any ack in IDLE/RESP).
REQ-013 Timeout counter width SHALL be clog2(TIMEOUT_CYCLES+1); cleared on accept; increments each READ/WRITE cycle with ack low.
REQ-014 If TIMEOUT_CYCLES>0 and the request has been high TIMEOUT_CYCLES consecutive cycles with ack low, SHALL go RESP with rsp_error=1, rsp_rdata=0.
REQ-015 Ack on the same edge as timeout SHALL win: normal completion, rsp_error=0.
REQ-016 rsp_valid SHALL be high exactly in RESP; rsp_rdata/rsp_error stable while rsp_valid high; on rsp_valid & rsp_ready return to IDLE.
REQ-017 Minimum latency: accept edge N, request high cycle N+1, ack sampled edge N+1 gives rsp_valid at N+2; back-to-back commands spaced at least 3 cycles.
REQ-018 Counter SHALL not wrap; it saturates at TIMEOUT_CYCLES when TIMEOUT_CYCLES=0 (disabled, request held indefinitely).

Reset
REQ-019 rstn low SHALL asynchronously force IDLE; up_rreq, up_wreq, rsp_valid, rsp_error, busy = 0; rsp_rdata, up_raddr, up_waddr, up_wdata, counter = 0.
REQ-020 Reset mid-transaction SHALL drop request immediately and discard the transaction; no response is produced after release.
REQ-021 First command SHALL be accepted no earlier than the first edge after rstn rises.

Verification
REQ-022 Read: cmd addr 0x004, responder acks 1 cycle after up_rreq with up_rdata 0x0000_00A5 -> up_raddr=0x004 during request, rsp_valid with rsp_rdata 0x0000_00A5, rsp_error 0.
REQ-023 Write: cmd addr 0x000, wdata 0x0000_000F, ack after 2 cycles -> up_wreq high exactly 2 cycles, up_wdata stable, rsp_rdata 0, rsp_error 0.
REQ-024 Timeout: TIMEOUT_CYCLES=4, no ack -> up_rreq high exactly 4 cycles, then rsp_valid, rsp_error 1, rsp_rdata 0; ack on cycle 4 instead -> rsp_error 0.
REQ-025 Backpressure: rsp_ready low 5 cycles -> rsp_valid held, data stable, cmd_ready low, no new request issued.
REQ-026 Reset mid-write: rstn low during WRITE -> up_wreq 0 immediately, busy 0; after release, next read completes normally.
